osc_trace_renderer: RTL and testbench

//  Pixel-colour stage directly downstream of the 640x480@60Hz VGA timing generator. Consumes its

---
 rtl/osc_pkg.sv | 31 +++
 rtl/osc_line_ram.sv | 30 +++
 rtl/osc_trace_renderer.sv | 168 ++++++++++++++++
 tb/tb_osc_trace_renderer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osc_pkg.sv
// Shared constants, colour and write-FSM types for the oscilloscope trace renderer.
package osc_pkg;

   localparam int H_ACTIVE  = 640;
   localparam int V_ACTIVE  = 480;
   localparam int GRID_H    = 64;
   localparam int GRID_V    = 48;
   localparam int RAM_DEPTH = 2 * H_ACTIVE;
   localparam int RAM_AW    = $clog2(RAM_DEPTH);

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   localparam rgb_t COL_TRACE = 24'hFFFF00;
   localparam rgb_t COL_GRID  = 24'h404040;
   localparam rgb_t COL_BG    = 24'h000000;

   typedef enum logic {
      FILL,
      FULL
   } wr_state_t;

   // Banks are packed back to back (bank 1 starts at H_ACTIVE) so the RAM is exactly two lines deep.
   function automatic logic [RAM_AW-1:0] ram_index(input logic bank, input logic [9:0] addr);
      return bank ? RAM_AW'(addr) + RAM_AW'(H_ACTIVE) : RAM_AW'(addr);
   endfunction

endpackage

// File: rtl/osc_line_ram.sv
// Simple dual-port line RAM: one write port, one registered read port, both on Main_CLK.
module osc_line_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 1280,
   parameter int ADDR_W = 11
) (
   input  logic              Main_CLK,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   // NOTE: the storage array has no reset; clearing it would stop it mapping onto block RAM.
   always_ff @(posedge Main_CLK) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
      if (rd_addr < ADDR_W'(DEPTH)) begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/osc_trace_renderer.sv
// Pixel-colour stage: ping-pong capture buffer, frame-aligned bank swap and 3-stage trace render.
// Define GRID_EN to overlay the 10x10 graticule; without it non-trace pixels are black.
module osc_trace_renderer #(
   parameter int SAMPLE_W = 8,
   parameter int Y_OFFSET = 112,
   parameter int H_ACTIVE = 640
) (
   input  logic                Main_CLK,
   input  logic                Reset,
   input  logic [9:0]          H_Pixel,
   input  logic [9:0]          V_Pixel,
   input  logic                Blank_N,
   input  logic                Frame_Start,
   input  logic                Freeze,
   input  logic                Samp_Valid,
   input  logic [SAMPLE_W-1:0] Samp_Data,
   output logic                Samp_Ready,
   output logic                Frame_Swap,
   output logic [7:0]          VGA_R,
   output logic [7:0]          VGA_G,
   output logic [7:0]          VGA_B
);

   import osc_pkg::*;

   wr_state_t           state_q, state_d;
   logic                disp_bank_q, disp_bank_d;
   logic [9:0]          wr_addr_q, wr_addr_d;
   logic                back_full_q, back_full_d;
   logic                fs_d_q, fs_d_d;
   logic                samp_ready_q, samp_ready_d;
   logic                frame_swap_q, frame_swap_d;
   logic                ram_we;
   logic                swap_now;
   logic [SAMPLE_W-1:0] rd_data;

   logic [9:0]          h1_q, h1_d, v1_q, v1_d, hprev_q, hprev_d;
   logic                blank1_q, blank1_d;
   logic [9:0]          y_hold_q, y_hold_d, y_prev_q, y_prev_d;
   logic [9:0]          y_cur, y_prev, y_lo, y_hi;
   logic                new_col, trace_hit, grid_hit;
   rgb_t                rgb_q, rgb_d;

   osc_line_ram #(
      .DATA_W (SAMPLE_W),
      .DEPTH  (RAM_DEPTH),
      .ADDR_W (RAM_AW)
   ) u_line_ram (
      .Main_CLK (Main_CLK),
      .wr_en    (ram_we),
      .wr_addr  (ram_index(~disp_bank_q, wr_addr_q)),
      .wr_data  (Samp_Data),
      .rd_addr  (ram_index(disp_bank_q, H_Pixel)),
      .rd_data  (rd_data)
   );

   // NOTE: every signal gets its default first, so no path through this block can infer a latch.
   always_comb begin
      state_d      = state_q;
      disp_bank_d  = disp_bank_q;
      wr_addr_d    = wr_addr_q;
      back_full_d  = back_full_q;
      frame_swap_d = 1'b0;
      ram_we       = 1'b0;
      fs_d_d       = Frame_Start;
      swap_now     = Frame_Start && !fs_d_q && back_full_q && !Freeze;

      unique case (state_q)
         FILL: begin
            if (Samp_Valid && samp_ready_q) begin
               ram_we    = 1'b1;
               wr_addr_d = wr_addr_q + 10'd1;
               if (wr_addr_q == 10'(H_ACTIVE - 1)) begin
                  state_d     = FULL;
                  back_full_d = 1'b1;
               end
            end
         end
         FULL: begin
            if (swap_now) begin
               state_d      = FILL;
               disp_bank_d  = ~disp_bank_q;
               wr_addr_d    = '0;
               back_full_d  = 1'b0;
               frame_swap_d = 1'b1;
            end
         end
      endcase
      samp_ready_d = (state_d == FILL);

      // Reset is synchronous, so it is folded into the next-state values here.
      if (!Reset) begin
         state_d      = FILL;
         disp_bank_d  = 1'b0;
         wr_addr_d    = '0;
         back_full_d  = 1'b0;
         fs_d_d       = 1'b0;
         samp_ready_d = 1'b0;
         frame_swap_d = 1'b0;
         ram_we       = 1'b0;
      end
   end

   always_comb begin
      h1_d     = H_Pixel;
      v1_d     = V_Pixel;
      blank1_d = Blank_N;
      hprev_d  = h1_q;
      y_cur    = 10'(Y_OFFSET) + (10'((2 ** SAMPLE_W) - 1) - 10'(rd_data));
      y_hold_d = y_cur;
      // The pixel clock is half Main_CLK, so a column repeats; y_prev advances only on a new column.
      new_col  = (h1_q != hprev_q);
      y_prev_d = new_col ? y_hold_q : y_prev_q;
      y_prev   = (h1_q == '0) ? y_cur : y_prev_d;
      y_lo     = (y_prev < y_cur) ? y_prev : y_cur;
      y_hi     = (y_prev < y_cur) ? y_cur : y_prev;
      trace_hit = (v1_q >= y_lo) && (v1_q <= y_hi);
`ifdef GRID_EN
      grid_hit = ((h1_q % 10'(GRID_H)) == '0) || ((v1_q % 10'(GRID_V)) == '0) ||
                 (h1_q == 10'(H_ACTIVE - 1)) || (v1_q == 10'(V_ACTIVE - 1));
`else
      grid_hit = 1'b0;
`endif
      rgb_d = COL_BG;
      if (blank1_q) begin
         if (trace_hit) begin
            rgb_d = COL_TRACE;
         end else if (grid_hit) begin
            rgb_d = COL_GRID;
         end
      end

      if (!Reset) begin
         h1_d     = '0;
         v1_d     = '0;
         blank1_d = 1'b0;
         hprev_d  = '0;
         y_hold_d = '0;
         y_prev_d = '0;
         rgb_d    = COL_BG;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Main_CLK) begin
      state_q      <= state_d;
      disp_bank_q  <= disp_bank_d;
      wr_addr_q    <= wr_addr_d;
      back_full_q  <= back_full_d;
      fs_d_q       <= fs_d_d;
      samp_ready_q <= samp_ready_d;
      frame_swap_q <= frame_swap_d;
      h1_q         <= h1_d;
      v1_q         <= v1_d;
      blank1_q     <= blank1_d;
      hprev_q      <= hprev_d;
      y_hold_q     <= y_hold_d;
      y_prev_q     <= y_prev_d;
      rgb_q        <= rgb_d;
   end

   assign Samp_Ready = samp_ready_q;
   assign Frame_Swap = frame_swap_q;
   assign VGA_R      = rgb_q.r;
   assign VGA_G      = rgb_q.g;
   assign VGA_B      = rgb_q.b;

endmodule

// File: tb/tb_osc_trace_renderer.sv
// Scoreboard bench for osc_trace_renderer: expected pixels queued at drive time, compared 2 cycles later.
module tb_osc_trace_renderer;

   logic       Main_CLK = 1'b0;
   logic       Reset = 1'b0;
   logic [9:0] H_Pixel = '0;
   logic [9:0] V_Pixel = '0;
   logic       Blank_N = 1'b0;
   logic       Frame_Start = 1'b0;
   logic       Freeze = 1'b0;
   logic       Samp_Valid = 1'b0;
   logic [7:0] Samp_Data = '0;
   logic       Samp_Ready, Frame_Swap;
   logic [7:0] VGA_R, VGA_G, VGA_B;

   osc_trace_renderer dut (
      .Main_CLK    (Main_CLK),
      .Reset       (Reset),
      .H_Pixel     (H_Pixel),
      .V_Pixel     (V_Pixel),
      .Blank_N     (Blank_N),
      .Frame_Start (Frame_Start),
      .Freeze      (Freeze),
      .Samp_Valid  (Samp_Valid),
      .Samp_Data   (Samp_Data),
      .Samp_Ready  (Samp_Ready),
      .Frame_Swap  (Frame_Swap),
      .VGA_R       (VGA_R),
      .VGA_G       (VGA_G),
      .VGA_B       (VGA_B)
   );

   always #10 Main_CLK = ~Main_CLK;

   typedef struct {
      bit          chk;
      int          h;
      int          v;
      logic [23:0] rgb;
   } sb_t;

   sb_t        sb_q[$];
   logic [7:0] img[2][640];
   int         checks = 0;
   int         errors = 0;
   int         m_disp = 0;
   int         m_wr = 0;
   bit         m_full = 1'b0;
   bit         stalled = 1'b0;
   bit         done = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int y_of(input logic [7:0] s);
      return 112 + 255 - int'(s);
   endfunction

   // Reference pixel colour for the displayed capture; assumes column h-1 was scanned just before h.
   function automatic logic [23:0] model_rgb(input int h, input int v, input bit blank);
      int yc, yp, lo, hi;
      if (!blank) return 24'h000000;
      yc = y_of(img[m_disp][h]);
      yp = (h == 0) ? yc : y_of(img[m_disp][h-1]);
      lo = (yc < yp) ? yc : yp;
      hi = (yc < yp) ? yp : yc;
      if (v >= lo && v <= hi) return 24'hFFFF00;
`ifdef GRID_EN
      if (h % 64 == 0 || v % 48 == 0 || h == 639 || v == 479) return 24'h404040;
`endif
      return 24'h000000;
   endfunction

   function automatic logic [7:0] pat(input int kind, input int x);
      logic [7:0] xb;
      xb = x[7:0];
      case (kind)
         0:       return 8'h80;
         1:       return xb;
         2:       return 8'(x * 3);
         3:       return 8'hFF - xb;
         default: return xb ^ 8'h5A;
      endcase
   endfunction

   task automatic drive_px(input int h, input int v, input bit blank, input bit chk);
      sb_t e;
      @(negedge Main_CLK);
      if (sb_q.size() == 2) begin
         e = sb_q.pop_front();
         if (e.chk) check($sformatf("rgb_h%0d_v%0d", e.h, e.v), {8'h00, VGA_R, VGA_G, VGA_B}, {8'h00, e.rgb});
      end
      H_Pixel = 10'(h);
      V_Pixel = 10'(v);
      Blank_N = blank;
      e.chk = chk;
      e.h   = h;
      e.v   = v;
      e.rgb = model_rgb(h, v, blank);
      sb_q.push_back(e);
   endtask

   task automatic render_run(input int v, input int x0, input int x1, input bit blank = 1'b1);
      for (int x = (x0 > 0 ? x0 - 1 : 0); x <= x1; x++) begin
         repeat (2) drive_px(x, v, blank, x >= x0);
      end
      repeat (2) drive_px(0, 0, 1'b0, 1'b0);
   endtask

   task automatic fill(input int n, input int kind);
      int t;
      for (int k = 0; k < n && !stalled; k++) begin
         @(negedge Main_CLK);
         Samp_Valid = 1'b0;
         t = 0;
         while (!Samp_Ready && t < 50) begin
            @(negedge Main_CLK);
            t++;
         end
         if (!Samp_Ready) begin
            check("ready_wait", {31'd0, Samp_Ready}, 32'd1);
            stalled = 1'b1;
         end else begin
            Samp_Valid = 1'b1;
            Samp_Data  = pat(kind, m_wr);
            img[1-m_disp][m_wr] = pat(kind, m_wr);
            m_wr++;
            if (m_wr == 640) m_full = 1'b1;
         end
      end
      @(negedge Main_CLK);
      Samp_Valid = 1'b0;
   endtask

   // Holds Frame_Start high for several cycles and counts Frame_Swap cycles around the edge.
   task automatic frame_edge(input string tag);
      bit exp;
      int cnt;
      exp = m_full && !Freeze;
      cnt = 0;
      @(negedge Main_CLK);
      Frame_Start = 1'b1;
      repeat (4) begin
         @(negedge Main_CLK);
         cnt += int'(Frame_Swap);
      end
      Frame_Start = 1'b0;
      repeat (3) begin
         @(negedge Main_CLK);
         cnt += int'(Frame_Swap);
      end
      check(tag, cnt, {31'd0, exp});
      if (exp) begin
         m_disp = 1 - m_disp;
         m_wr   = 0;
         m_full = 1'b0;
      end
   endtask

   initial begin
      int cnt;
      // Reset state
      repeat (3) @(negedge Main_CLK);
      check("rst_rgb", {8'h00, VGA_R, VGA_G, VGA_B}, 32'd0);
      check("rst_ready", {31'd0, Samp_Ready}, 32'd0);
      check("rst_swap", {31'd0, Frame_Swap}, 32'd0);
      Reset = 1'b1;
      @(negedge Main_CLK);
      check("ready_after_rst", {31'd0, Samp_Ready}, 32'd1);

      // Flat capture: row 239 across the whole line
      fill(640, 0);
      check("ready_full", {31'd0, Samp_Ready}, 32'd0);
      frame_edge("swap_flat");
      render_run(239, 0, 639);
      render_run(240, 0, 639);
      render_run(96, 60, 70);
      render_run(239, 10, 12, 1'b0);

      // Ramp capture: full-height segment at the 255/256 wrap
      fill(640, 1);
      frame_edge("swap_ramp");
      render_run(112, 250, 260);
      render_run(367, 250, 260);
      render_run(300, 250, 260);
      render_run(367, 0, 3);
      render_run(366, 0, 3);

      // Partial fill: no swap, old image stays
      fill(400, 3);
      frame_edge("swap_partial");
      check("ready_partial", {31'd0, Samp_Ready}, 32'd1);
      render_run(367, 250, 260);

      // Full buffer held by Freeze for three frames
      fill(240, 3);
      check("ready_full2", {31'd0, Samp_Ready}, 32'd0);
      Freeze = 1'b1;
      for (int f = 0; f < 3; f++) begin
         frame_edge($sformatf("swap_freeze%0d", f));
         check($sformatf("ready_freeze%0d", f), {31'd0, Samp_Ready}, 32'd0);
      end
      render_run(200, 160, 170);
      Freeze = 1'b0;
      frame_edge("swap_unfreeze");
      render_run(212, 95, 105);

      // 640th sample coincides with the Frame_Start rising edge
      fill(639, 2);
      @(negedge Main_CLK);
      Samp_Valid  = 1'b1;
      Samp_Data   = pat(2, m_wr);
      img[1-m_disp][m_wr] = pat(2, m_wr);
      m_wr        = 640;
      Frame_Start = 1'b1;
      cnt = 0;
      @(negedge Main_CLK);
      Samp_Valid = 1'b0;
      cnt += int'(Frame_Swap);
      repeat (3) begin
         @(negedge Main_CLK);
         cnt += int'(Frame_Swap);
      end
      Frame_Start = 1'b0;
      repeat (3) begin
         @(negedge Main_CLK);
         cnt += int'(Frame_Swap);
      end
      check("swap_coincident", cnt, 32'd0);
      check("ready_coincident", {31'd0, Samp_Ready}, 32'd0);
      m_full = 1'b1;
      frame_edge("swap_deferred");
      render_run(367, 0, 10);
      render_run(352, 3, 7);

      // Reset mid-fill with a trace pixel presented
      fill(300, 4);
      @(negedge Main_CLK);
      Reset      = 1'b0;
      Samp_Valid = 1'b1;
      H_Pixel    = 10'd5;
      V_Pixel    = 10'd353;
      Blank_N    = 1'b1;
      repeat (2) @(negedge Main_CLK);
      check("midrst_rgb", {8'h00, VGA_R, VGA_G, VGA_B}, 32'd0);
      check("midrst_ready", {31'd0, Samp_Ready}, 32'd0);
      check("midrst_swap", {31'd0, Frame_Swap}, 32'd0);
      Reset      = 1'b1;
      Samp_Valid = 1'b0;
      Blank_N    = 1'b0;
      m_disp     = 0;
      m_wr       = 0;
      m_full     = 1'b0;
      @(negedge Main_CLK);
      check("ready_after_midrst", {31'd0, Samp_Ready}, 32'd1);
      render_run(10, 62, 66);
      render_run(352, 4, 6);

      // Fresh capture after reset must start at address 0
      fill(640, 4);
      frame_edge("swap_after_rst");
      render_run(200, 0, 639);

      done = 1'b1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_500_000;
      check("watchdog_done", {31'd0, done}, 32'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
